// File: rtl/system_control_pkg.sv
// Shared types and constants for the system run controller and its helpers.
package system_control_pkg;

    localparam int SYSTEM_RUN_COUNT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESETTING = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_CONFIRM   = 3'd4,
        ST_DONE      = 3'd5
    } run_state_t;

    // The PE is only considered finished when nothing is left in flight anywhere.
    function automatic logic halt_condition(input logic pe_halted,
                                            input logic pe_channels_quiescent,
                                            input logic memory_quiescent);
        return pe_halted & pe_channels_quiescent & memory_quiescent;
    endfunction

endpackage

// File: rtl/system_run_controller_if.sv
// Host/PE-facing signal bundle of the run controller: control in, status and PE controls out.
interface system_run_controller_if
    import system_control_pkg::*;
#(
    parameter int COUNT_WIDTH = SYSTEM_RUN_COUNT_WIDTH
) ();

    logic                   start;
    logic                   abort;
    logic [COUNT_WIDTH-1:0] timeout_limit;
    logic                   pe_halted;
    logic                   pe_channels_quiescent;
    logic                   memory_quiescent;
    logic                   system_reset;
    logic                   system_enable;
    logic                   system_execute;
    logic                   busy;
    logic                   done;
    logic                   timed_out;
    logic                   aborted;
    logic [COUNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, abort, timeout_limit,
        output pe_halted, pe_channels_quiescent, memory_quiescent,
        input  system_reset, system_enable, system_execute,
        input  busy, done, timed_out, aborted, cycle_count
    );

    modport slave (
        input  start, abort, timeout_limit,
        input  pe_halted, pe_channels_quiescent, memory_quiescent,
        output system_reset, system_enable, system_execute,
        output busy, done, timed_out, aborted, cycle_count
    );

endinterface

// File: rtl/saturating_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear dominates increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/system_run_controller.sv
// Sequences one PE test run (reset pulse, settle, execute), qualifies the halt condition
// over several cycles and ends the run on confirmed halt, timeout or host abort.
module system_run_controller
    import system_control_pkg::*;
#(
    parameter int RESET_CYCLES        = 4,
    parameter int HALT_CONFIRM_CYCLES = 3,
    parameter int COUNT_WIDTH         = SYSTEM_RUN_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    system_run_controller_if.slave bus
);

    localparam int RESET_WIDTH   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int CONFIRM_WIDTH = $clog2(HALT_CONFIRM_CYCLES + 1);
    localparam logic [RESET_WIDTH-1:0]   RESET_LAST   = RESET_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CONFIRM_WIDTH-1:0] CONFIRM_LAST = CONFIRM_WIDTH'(HALT_CONFIRM_CYCLES - 1);

    run_state_t               state_q, state_d;
    logic [RESET_WIDTH-1:0]   reset_count_q, reset_count_d;
    logic [COUNT_WIDTH-1:0]   limit_q, limit_d;
    logic                     system_reset_q, system_reset_d;
    logic                     system_enable_q, system_enable_d;
    logic                     system_execute_q, system_execute_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     timed_out_q, timed_out_d;
    logic                     aborted_q, aborted_d;

    logic                     halt_s;
    logic                     timeout_hit_s;
    logic [COUNT_WIDTH-1:0]   cycle_count_s;
    logic [COUNT_WIDTH-1:0]   count_next_s;
    logic [CONFIRM_WIDTH-1:0] confirm_count_s;
    logic                     cycle_clear_s, cycle_inc_s;
    logic                     confirm_clear_s, confirm_inc_s;

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_cycle_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (cycle_clear_s),
        .increment (cycle_inc_s),
        .count     (cycle_count_s)
    );

    saturating_counter #(.WIDTH(CONFIRM_WIDTH)) u_confirm_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (confirm_clear_s),
        .increment (confirm_inc_s),
        .count     (confirm_count_s)
    );

    // Timeout fires on the cycle whose count would reach the latched limit.
    always_comb begin
        halt_s        = halt_condition(bus.pe_halted, bus.pe_channels_quiescent,
                                       bus.memory_quiescent);
        count_next_s  = (cycle_count_s == '1) ? cycle_count_s : cycle_count_s + COUNT_WIDTH'(1);
        timeout_hit_s = (limit_q != '0) && (count_next_s == limit_q);
    end

    // Next-state logic; outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        state_d          = state_q;
        reset_count_d    = reset_count_q;
        limit_d          = limit_q;
        done_d           = done_q;
        timed_out_d      = timed_out_q;
        aborted_d        = aborted_q;
        cycle_clear_s    = 1'b0;
        cycle_inc_s      = 1'b0;
        confirm_clear_s  = 1'b0;
        confirm_inc_s    = 1'b0;
        system_reset_d   = 1'b0;
        system_enable_d  = 1'b1;
        system_execute_d = 1'b0;
        busy_d           = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d         = ST_RESETTING;
                    reset_count_d   = '0;
                    limit_d         = bus.timeout_limit;
                    done_d          = 1'b0;
                    timed_out_d     = 1'b0;
                    aborted_d       = 1'b0;
                    cycle_clear_s   = 1'b1;
                    confirm_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESETTING: begin
                if (bus.abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (reset_count_q == RESET_LAST) begin
                    state_d = ST_SETTLE;
                end else begin
                    reset_count_d = reset_count_q + RESET_WIDTH'(1);
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_CONFIRM: begin
                // Every execute cycle is counted, including the one that ends the run.
                cycle_inc_s = 1'b1;
                if (bus.abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (halt_s && (confirm_count_s == CONFIRM_LAST)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (timeout_hit_s) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                end else if (halt_s) begin
                    state_d       = ST_CONFIRM;
                    confirm_inc_s = 1'b1;
                end else begin
                    state_d         = ST_RUN;
                    confirm_clear_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_RESETTING: begin
                system_reset_d  = 1'b1;
                system_enable_d = 1'b0;
                busy_d          = 1'b1;
            end
            ST_SETTLE: begin
                busy_d = 1'b1;
            end
            ST_RUN, ST_CONFIRM: begin
                system_execute_d = 1'b1;
                busy_d           = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset holds the PE in reset with everything else idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            reset_count_q    <= '0;
            limit_q          <= '0;
            system_reset_q   <= 1'b1;
            system_enable_q  <= 1'b0;
            system_execute_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            timed_out_q      <= 1'b0;
            aborted_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            reset_count_q    <= reset_count_d;
            limit_q          <= limit_d;
            system_reset_q   <= system_reset_d;
            system_enable_q  <= system_enable_d;
            system_execute_q <= system_execute_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            timed_out_q      <= timed_out_d;
            aborted_q        <= aborted_d;
        end
    end

    assign bus.system_reset   = system_reset_q;
    assign bus.system_enable  = system_enable_q;
    assign bus.system_execute = system_execute_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.timed_out      = timed_out_q;
    assign bus.aborted        = aborted_q;
    assign bus.cycle_count    = cycle_count_s;

endmodule

// File: tb/tb_system_run_controller.sv
// Randomised and directed runs against a run-outcome reference model; a monitor scores each completed run.
module tb_system_run_controller;
    import system_control_pkg::*;

    localparam int RESET_CYCLES = 4;
    localparam int HALT_CONFIRM = 3;
    localparam int PAT_LEN      = 128;

    typedef struct {
        int timed_out;
        int aborted;
        int count;
        int rst_cycles;
        int settle_cycles;
    } exp_t;

    logic clock;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   halt_pat [PAT_LEN];
    exp_t sb_q [$];

    system_run_controller_if #(.COUNT_WIDTH(SYSTEM_RUN_COUNT_WIDTH)) ifm ();
    system_run_controller_if #(.COUNT_WIDTH(4)) ifs ();

    system_run_controller #(
        .RESET_CYCLES(RESET_CYCLES), .HALT_CONFIRM_CYCLES(HALT_CONFIRM),
        .COUNT_WIDTH(SYSTEM_RUN_COUNT_WIDTH)
    ) dut (.clock(clock), .reset(rst), .bus(ifm.slave));

    system_run_controller #(
        .RESET_CYCLES(RESET_CYCLES), .HALT_CONFIRM_CYCLES(HALT_CONFIRM), .COUNT_WIDTH(4)
    ) dut_sat (.clock(clock), .reset(rst), .bus(ifs.slave));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run outcome from the rules: abort first, then HALT_CONFIRM consecutive halts, then limit.
    function automatic exp_t model(input int limit, input int abort_at);
        exp_t e;
        int   streak = 0;
        e.timed_out = 0; e.aborted = 0; e.count = 0;
        e.rst_cycles = RESET_CYCLES; e.settle_cycles = 1;
        if (abort_at == 0) begin
            e.aborted = 1; e.rst_cycles = 1; e.settle_cycles = 0;
            return e;
        end
        for (int n = 1; n < PAT_LEN; n++) begin
            e.count = n;
            if (abort_at == n) begin
                e.aborted = 1;
                return e;
            end
            streak = halt_pat[n] ? streak + 1 : 0;
            if (streak >= HALT_CONFIRM) return e;
            if (limit != 0 && n == limit) begin
                e.timed_out = 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic drive_halt(input bit h);
        logic [2:0] v;
        v = h ? 3'b111 : 3'($urandom_range(0, 6));
        ifm.pe_halted             = v[2];
        ifm.pe_channels_quiescent = v[1];
        ifm.memory_quiescent      = v[0];
    endtask

    task automatic check_outputs(input string name, input logic [6:0] exp_bits, input int exp_count);
        check({name, "_bits"}, {ifm.system_reset, ifm.system_enable, ifm.system_execute, ifm.busy,
                                ifm.done, ifm.timed_out, ifm.aborted}, exp_bits);
        check({name, "_count"}, ifm.cycle_count, exp_count);
    endtask

    task automatic set_pattern(input int first_true, input int glitch_lo, input int glitch_hi);
        for (int i = 0; i < PAT_LEN; i++)
            halt_pat[i] = (first_true > 0 && i >= first_true) || (i >= glitch_lo && i <= glitch_hi);
    endtask

    // Issue one run (caller is at negedge+1); abort_at: -1 none, 0 during reset, n on execute cycle n.
    task automatic run_scenario(input int limit, input int abort_at);
        int n = 0;
        bit fin = 0;
        sb_q.push_back(model(limit, abort_at));
        ifm.start = 1'b1; ifm.abort = 1'b0; ifm.timeout_limit = 32'(limit);
        @(negedge clock); #1;
        ifm.start = 1'b0; ifm.timeout_limit = $urandom();
        check("start_clears_flags", {ifm.done, ifm.timed_out, ifm.aborted, ifm.busy, ifm.system_reset}, 5'b00011);
        check("start_clears_count", ifm.cycle_count, 0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            ifm.abort = 1'b0; ifm.start = 1'b0;
            if (ifm.done) begin
                fin = 1;
            end else if (ifm.system_execute) begin
                n++;
                drive_halt(halt_pat[(n < PAT_LEN) ? n : PAT_LEN - 1]);
                ifm.abort = (n == abort_at);
                ifm.start = (n == 1);
            end else begin
                drive_halt(1'($urandom_range(0, 1)));
                ifm.abort = (abort_at == 0) && ifm.system_reset;
            end
            if (!fin) begin
                @(negedge clock); #1;
            end
        end
        ifm.abort = 1'b0; ifm.start = 1'b0;
        check("run_finished", fin, 1);
    endtask

    task automatic run_reset_mid();
        int n = 0;
        bit hit = 0;
        set_pattern(0, 0, -1);
        ifm.start = 1'b1; ifm.timeout_limit = 32'd0;
        @(negedge clock); #1;
        ifm.start = 1'b0;
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            drive_halt(1'b0);
            if (ifm.system_execute) begin
                n++;
                hit = (n == 8);
            end
            if (!hit) begin
                @(negedge clock); #1;
            end
        end
        check("reset_mid_reached", hit, 1);
        rst = 1'b1;
        @(negedge clock); #1;
        check_outputs("reset_mid_state", 7'b1000000, 0);
        rst = 1'b0;
        @(negedge clock); #1;
        check_outputs("reset_release_state", 7'b0100000, 0);
    endtask

    task automatic run_saturation();
        int k = 0;
        int exp_c;
        bit fin = 0;
        ifs.start = 1'b1; ifs.timeout_limit = 4'd0;
        @(negedge clock); #1;
        ifs.start = 1'b0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            ifs.abort = 1'b0;
            if (ifs.done) begin
                fin = 1;
            end else if (ifs.system_execute) begin
                k++;
                exp_c = (k - 1 > 15) ? 15 : k - 1;
                check("sat_count_running", ifs.cycle_count, exp_c);
                ifs.abort = (k == 20);
            end
            if (!fin) begin
                @(negedge clock); #1;
            end
        end
        check("sat_run_finished", fin, 1);
        check("sat_flags", {ifs.aborted, ifs.timed_out}, 2'b10);
        check("sat_final_count", ifs.cycle_count, 15);
    endtask

    // Scoreboard monitor: tallies the phases of each run and scores it when done rises.
    int   m_rst = 0, m_settle = 0, m_exe = 0;
    bit   done_prev = 0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (rst) begin
            m_rst = 0; m_settle = 0; m_exe = 0; done_prev = 0;
        end else begin
            if (ifm.system_reset) m_rst++;
            if (ifm.system_enable && ifm.busy && !ifm.system_reset && !ifm.system_execute) m_settle++;
            if (ifm.system_execute) m_exe++;
            if (ifm.done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_unexpected_done: got done with empty scoreboard");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("run_timed_out", ifm.timed_out, mon_e.timed_out);
                    check("run_aborted", ifm.aborted, mon_e.aborted);
                    check("run_cycle_count", ifm.cycle_count, mon_e.count);
                    check("run_execute_cycles", m_exe, mon_e.count);
                    check("run_reset_cycles", m_rst, mon_e.rst_cycles);
                    check("run_settle_cycles", m_settle, mon_e.settle_cycles);
                    check("run_idle_outputs", {ifm.system_enable, ifm.system_execute, ifm.busy}, 3'b100);
                end
                m_rst = 0; m_settle = 0; m_exe = 0;
            end
            done_prev = ifm.done;
        end
    end

    initial begin
        int limit;
        int abort_at;
        int density;
        rst = 1'b1;
        ifm.start = 1'b0; ifm.abort = 1'b0; ifm.timeout_limit = '0;
        ifm.pe_halted = 1'b0; ifm.pe_channels_quiescent = 1'b0; ifm.memory_quiescent = 1'b0;
        ifs.start = 1'b0; ifs.abort = 1'b0; ifs.timeout_limit = '0;
        ifs.pe_halted = 1'b0; ifs.pe_channels_quiescent = 1'b0; ifs.memory_quiescent = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_outputs("reset_state", 7'b1000000, 0);
        rst = 1'b0;
        @(negedge clock); #1;
        check_outputs("first_idle_state", 7'b0100000, 0);

        set_pattern(10, 0, -1); run_scenario(0, -1);     // normal run -> 12
        set_pattern(15, 5, 6);  run_scenario(0, -1);     // halt glitch -> 17
        set_pattern(0, 0, -1);  run_scenario(50, -1);    // timeout -> 50
        set_pattern(0, 0, -1);  run_scenario(0, 20);     // abort -> 20
        run_scenario(0, 20);                             // rerun from DONE
        set_pattern(10, 0, -1); run_scenario(12, -1);    // confirm beats timeout
        set_pattern(10, 0, -1); run_scenario(0, 12);     // abort beats confirm
        set_pattern(0, 0, -1);  run_scenario(1, -1);     // minimum limit
        set_pattern(1, 0, -1);  run_scenario(0, -1);     // halt from first cycle -> 3
        set_pattern(10, 0, -1); run_scenario(0, 0);      // abort during reset pulse
        run_reset_mid();
        set_pattern(10, 0, -1); run_scenario(0, -1);     // normal after mid-run reset

        for (int r = 0; r < 20; r++) begin
            density = $urandom_range(0, 3);
            for (int i = 0; i < PAT_LEN; i++)
                halt_pat[i] = (i >= 80) || ($urandom_range(0, 3) < density);
            limit    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 70);
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 60) : -1;
            run_scenario(limit, abort_at);
        end

        repeat (4) @(negedge clock);
        #1;
        check("sb_drained", sb_q.size(), 0);
        run_saturation();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
